multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the 24-bit multicycle CPU.
- Sequences fetch/decode/execute/memory/writeback over one shared ALU, one shared memory port and the register file.
- Drives alu_op[1:0] into ALUControl: 00 = add, 01 = sub, 10 = decode funct.
- Decodes opcode = instr[23:20] and stalls on memory via mem_ready.

Parameters:
- OP_R, 4'b0000, R-type (ALU op chosen by funct)
- OP_LW, 4'b0100, load word
- OP_SW, 4'b0101, store word
- OP_BEQ, 4'b0110, branch if equal
- OP_ADDI, 4'b0111, add immediate
- OP_J, 4'b1000, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  leave IDLE and start fetching
- opcode  in  4  IR[23:20]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 1, 10 sign-ext imm, 11 branch offset
- alu_op  out  2  to ALUControl
- state  out  4  current state encoding (debug)
- instr_done  out  1  1-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky: unknown opcode was decoded

Behaviour:
- State register updates on the rising clk edge. rst_n=0 forces IDLE immediately, asynchronously, including mid-instruction.
- Reset/IDLE output values: every output is 0, except state=0 and illegal cleared to 0.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, ALUWB=8, BRANCH=9, ADDIEX=10, JUMP=11, TRAP=12.
- Outputs are Moore decodes of state, except the mem_ready- and zero-qualified strobes listed per state. Any output not listed for a state is 0.
- IDLE: go to FETCH when run=1.
- FETCH:
  - Always: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
  - PC advances exactly once per instruction.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode: LW/SW -> MEMADR, R -> REX, BEQ -> BRANCH, ADDI -> ADDIEX, J -> JUMP, other -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_read=1, iord=1. Stay until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEMWR: mem_write=1, iord=1. Stay until mem_ready=1; that cycle instr_done=1 and -> FETCH. mem_write stays high during the wait.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB:
  - reg_write=1, mem_to_reg=0, instr_done=1 -> FETCH.
  - reg_dst=1 when reached from REX, 0 when reached from ADDIEX; held in a 1-bit flag.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ALUWB.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = zero.
  - instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- TRAP: illegal set to 1 and held; all strobes 0. Leaves only on reset.
- Latency with mem_ready=1 on first request:
  - LW 5 cycles, SW 4, R 4, ADDI 4, BEQ 3, J 3.
  - Each memory wait cycle adds 1.
- run is sampled only in IDLE; deasserting run mid-program has no effect.

Test Plan:
- Reset mid-MEMRD (rst_n low 3 cycles) -> state=0 immediately; all outputs 0; stays IDLE while run=0; run=1 -> FETCH next edge.
- run=1, mem_ready=1, opcode=0000 -> states 1,2,7,8,1. In REX alu_op=10. In ALUWB reg_write=1, reg_dst=1, instr_done=1. pc_write=1 for exactly one cycle.
- opcode=0100, mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD:
  - FETCH lasts 3 cycles; ir_write and pc_write pulse only on its 3rd cycle.
  - MEMRD lasts 4 cycles; then MEMWB with mem_to_reg=1, reg_dst=0.
- opcode=0110: with zero=1 -> pc_write=1, pc_src=01, alu_op=01 in BRANCH. Repeat with zero=0 -> pc_write=0. Both take 3 cycles.
- opcode=0101 then 0111:
  - SW: mem_write=1, iord=1 in MEMWR; no reg_write at any point.
  - ADDI: ALUWB with reg_dst=0, alu_src_b=10 in ADDIEX.
- opcode=1111 -> DECODE then TRAP(12), illegal=1 held for 10 cycles, no strobes asserted; rst_n pulse clears illegal.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the 24-bit multicycle CPU
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t cur, nxt;
    logic   rtype_q;
    logic   illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            rtype_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            cur <= nxt;
            // ALUWB is shared by R-type and ADDI; remember which one got us there
            if (cur == S_REX)
                rtype_q <= 1'b1;
            else if (cur == S_ADDIEX)
                rtype_q <= 1'b0;
            if (nxt == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (cur)
            S_IDLE: begin
                if (run)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_REX;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt        = S_FETCH;
                end
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = rtype_q;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_TRAP: begin
                nxt = S_TRAP;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    assign state   = cur;
    assign illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    typedef struct packed {
        obs_t       e;
        logic       mr;
        logic       z;
        logic [3:0] op;
    } rec_t;

    obs_t obs;
    rec_t q[$];

    assign obs = {state, pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal};

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    task automatic check(input string tag, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic obs_t st(input logic [3:0] s);
        obs_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t e, input logic mr, input logic z, input logic [3:0] op);
        rec_t r;
        r.e = e; r.mr = mr; r.z = z; r.op = op;
        q.push_back(r);
    endtask

    // Expected per-cycle trace of one instruction; fw/mw are memory wait cycles.
    task automatic gen_instr(input logic [3:0] op, input int fw, input int mw,
                             input logic z, input int trap_cycles);
        obs_t o;
        o = st(4'd1); o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        for (int i = 0; i < fw; i++) push(o, 1'b0, rb(), op);
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, 1'b1, rb(), op);
        o = st(4'd2); o.alu_src_b = 2'b11;
        push(o, rb(), rb(), op);
        case (op)
            4'b0100, 4'b0101: begin
                o = st(4'd3); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(o, rb(), rb(), op);
                if (op == 4'b0100) begin
                    o = st(4'd4); o.mem_read = 1'b1; o.iord = 1'b1;
                    for (int i = 0; i < mw; i++) push(o, 1'b0, rb(), op);
                    push(o, 1'b1, rb(), op);
                    o = st(4'd5); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    push(o, rb(), rb(), op);
                end else begin
                    o = st(4'd6); o.mem_write = 1'b1; o.iord = 1'b1;
                    for (int i = 0; i < mw; i++) push(o, 1'b0, rb(), op);
                    o.instr_done = 1'b1;
                    push(o, 1'b1, rb(), op);
                end
            end
            4'b0000, 4'b0111: begin
                if (op == 4'b0000) begin
                    o = st(4'd7); o.alu_src_a = 1'b1; o.alu_op = 2'b10;
                end else begin
                    o = st(4'd10); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                end
                push(o, rb(), rb(), op);
                o = st(4'd8); o.reg_write = 1'b1; o.instr_done = 1'b1;
                o.reg_dst = (op == 4'b0000);
                push(o, rb(), rb(), op);
            end
            4'b0110: begin
                o = st(4'd9); o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01;
                o.pc_write = z; o.instr_done = 1'b1;
                push(o, rb(), z, op);
            end
            4'b1000: begin
                o = st(4'd11); o.pc_src = 2'b10; o.pc_write = 1'b1; o.instr_done = 1'b1;
                push(o, rb(), rb(), op);
            end
            default: begin
                o = st(4'd12); o.illegal = 1'b1;
                for (int i = 0; i < trap_cycles; i++) push(o, rb(), rb(), op);
            end
        endcase
    endtask

    task automatic play(input string tag);
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(posedge clk); #1;
            mem_ready = r.mr; zero = r.z; opcode = r.op; run = rb();
            #3;
            check($sformatf("%s_st%0d", tag, r.e.state), r.e);
        end
    endtask

    task automatic idle_checks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #4;
            check(tag, st(4'd0));
        end
    endtask

    initial begin
        logic [3:0] legal [6];
        legal[0] = 4'b0000; legal[1] = 4'b0100; legal[2] = 4'b0101;
        legal[3] = 4'b0110; legal[4] = 4'b0111; legal[5] = 4'b1000;

        #2;
        check("reset_low", st(4'd0));
        @(negedge clk); rst_n = 1'b1;
        idle_checks(2, "idle_run0");
        run = 1'b1;

        // LW interrupted by reset while waiting in MEMRD
        gen_instr(4'b0100, 0, 5, 1'b0, 0);
        void'(q.pop_back()); void'(q.pop_back()); void'(q.pop_back());
        void'(q.pop_back());
        play("lw_pre_reset");
        #1; run = 1'b0; rst_n = 1'b0; #1;
        check("async_reset", st(4'd0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #4;
            check("reset_hold", st(4'd0));
        end
        @(negedge clk); rst_n = 1'b1;
        idle_checks(3, "idle_after_reset");
        run = 1'b1;

        gen_instr(4'b0000, 0, 0, 1'b0, 0);
        gen_instr(4'b0100, 2, 3, 1'b0, 0);
        gen_instr(4'b0110, 0, 0, 1'b1, 0);
        gen_instr(4'b0110, 0, 0, 1'b0, 0);
        gen_instr(4'b0101, 1, 2, 1'b0, 0);
        gen_instr(4'b0111, 0, 0, 1'b0, 0);
        gen_instr(4'b1000, 0, 0, 1'b0, 0);
        play("directed");

        for (int n = 0; n < 40; n++)
            gen_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 3), rb(), 0);
        play("random");

        gen_instr(4'b1111, $urandom_range(0, 1), 0, 1'b0, 10);
        play("trap");

        #1; rst_n = 1'b0; run = 1'b0; #1;
        check("trap_reset_clears", st(4'd0));
        @(negedge clk); rst_n = 1'b1;
        idle_checks(2, "idle_after_trap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
